uart_rx_core: RTL and testbench

- Serial-to-parallel UART receiver: 8N1 format (1 start, 8 data LSB-first, 1 stop), no parity.
- Peer of the UART transmitter that drives o_Tx_Serial.
- Samples i_Rx_Serial at mid-bit, using a clocks-per-bit counter derived from i_Clock.
- Presents each good byte with a one-cycle valid strobe; flags framing errors.
- Sits in the UART top-level beside the transmitter, with i_Rx_Serial routed straight from the pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_bit_sync.sv | 26 ++
 rtl/uart_rx_core.sv | 147 ++++++++++++++
 tb/tb_uart_rx_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input pin.
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte-valid and framing-error strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Active
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_async (i_Rx_Serial),
    .o_sync  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, ferr_d;
  logic                 active_q, active_d;
  logic [1:0]           settle_q, settle_d;
  logic                 armed_q, armed_d;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
    active_d  = active_q;
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // Arm only on a genuine high once the synchronizer has flushed its reset
    // value, so a line that is low when reset releases cannot start a frame.
    armed_d   = armed_q | (rx_s & (settle_q == 2'd3));

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start.
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: good bytes, back-to-back frames, glitch, break, reset, baud skew.
module tb_uart_rx_core;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Active    (o_Rx_Active)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0] rx_bytes[$];
  int         dv_times[$];
  int         ferr_cnt = 0, act_cycles = 0, both_cnt = 0, consec_cnt = 0;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (o_Rx_DV) begin
        rx_bytes.push_back(o_Rx_Byte);
        dv_times.push_back(cycle);
      end
      if (o_Rx_Frame_Err) ferr_cnt++;
      if (o_Rx_Active) act_cycles++;
      if (o_Rx_DV && o_Rx_Frame_Err) both_cnt++;
      if ((o_Rx_DV || o_Rx_Frame_Err) && prev_strobe) consec_cnt++;
      prev_strobe = o_Rx_DV || o_Rx_Frame_Err;
    end
  end

  int vectors = 0, miscompares = 0;
  int t_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [31:0] byte_at(input int idx);
    return (rx_bytes.size() > idx) ? {24'h0, rx_bytes[idx]} : 32'hDEAD;
  endfunction

  function automatic int gap(input int idx);
    return (dv_times.size() > idx) ? dv_times[idx] - dv_times[idx-1] : -1;
  endfunction

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v);
    t_fall = cycle;
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop_v, per);
  endtask

  task automatic clear_mon();
    rx_bytes.delete();
    dv_times.delete();
    ferr_cnt   = 0;
    act_cycles = 0;
  endtask

  initial begin
    logic [7:0] c3;
    int         lat;
    c3 = 8'hC3;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dv",     {31'h0, o_Rx_DV},        32'h0);
    check("reset_byte",   {24'h0, o_Rx_Byte},      32'h0);
    check("reset_ferr",   {31'h0, o_Rx_Frame_Err}, 32'h0);
    check("reset_active", {31'h0, o_Rx_Active},    32'h0);
    rst = 1'b0;
    hold(1'b1, 100);

    // Single byte, latency and active window
    clear_mon();
    send_frame(8'hA5, CPB, 1'b1);
    lat = t_fall;
    hold(1'b1, 200);
    check("t1_dv_count", rx_bytes.size(), 1);
    check("t1_byte", byte_at(0), 32'hA5);
    check("t1_latency", {31'h0, (dv_times.size() == 1) && in_rng(dv_times[0] - lat, 828, 831)}, 32'h1);
    check("t1_active_len", {31'h0, in_rng(act_cycles, 782, 784)}, 32'h1);
    check("t1_ferr", ferr_cnt, 0);

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h00, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    send_frame(8'h3C, CPB, 1'b1);
    hold(1'b1, 300);
    check("t2_dv_count", rx_bytes.size(), 3);
    check("t2_byte0", byte_at(0), 32'h00);
    check("t2_byte1", byte_at(1), 32'hFF);
    check("t2_byte2", byte_at(2), 32'h3C);
    check("t2_gap1", {31'h0, in_rng(gap(1), 10*CPB-1, 10*CPB+1)}, 32'h1);
    check("t2_gap2", {31'h0, in_rng(gap(2), 10*CPB-1, 10*CPB+1)}, 32'h1);
    check("t2_ferr", ferr_cnt, 0);

    // Short low glitch must not start a frame
    clear_mon();
    hold(1'b0, 30);
    hold(1'b1, 200);
    check("t3_dv_count", rx_bytes.size(), 0);
    check("t3_ferr", ferr_cnt, 0);
    check("t3_active", act_cycles, 0);

    // Framing error followed by a long break
    clear_mon();
    send_frame(8'h5A, CPB, 1'b0);
    hold(1'b0, 2000);
    check("t4_ferr_count", ferr_cnt, 1);
    check("t4_dv_count", rx_bytes.size(), 0);
    check("t4_byte_hold", {24'h0, o_Rx_Byte}, 32'h3C);
    hold(1'b1, 300);
    check("t4_ferr_after_break", ferr_cnt, 1);
    check("t4_dv_after_break", rx_bytes.size(), 0);
    clear_mon();
    send_frame(8'h81, CPB, 1'b1);
    hold(1'b1, 200);
    check("t4_next_count", rx_bytes.size(), 1);
    check("t4_next_byte", byte_at(0), 32'h81);
    check("t4_next_ferr", ferr_cnt, 0);

    // Reset in the middle of data bit 4
    clear_mon();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(c3[i], CPB);
    hold(c3[4], 40);
    rst = 1'b1;
    #1;
    check("t5_rst_dv",     {31'h0, o_Rx_DV},        32'h0);
    check("t5_rst_byte",   {24'h0, o_Rx_Byte},      32'h0);
    check("t5_rst_ferr",   {31'h0, o_Rx_Frame_Err}, 32'h0);
    check("t5_rst_active", {31'h0, o_Rx_Active},    32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(c3[4], CPB - 43);
    for (int i = 5; i < 8; i++) hold(c3[i], CPB);
    hold(1'b1, CPB);
    hold(1'b1, 200);
    check("t5_partial_dv", rx_bytes.size(), 0);
    check("t5_partial_ferr", ferr_cnt, 0);
    send_frame(8'h7E, CPB, 1'b1);
    hold(1'b1, 200);
    check("t5_next_count", rx_bytes.size(), 1);
    check("t5_next_byte", byte_at(0), 32'h7E);

    // Transmitter bit period skewed by -2 and +2 clocks
    clear_mon();
    send_frame(8'h96, CPB - 2, 1'b1);
    hold(1'b1, 200);
    send_frame(8'h96, CPB + 2, 1'b1);
    hold(1'b1, 200);
    check("t6_dv_count", rx_bytes.size(), 2);
    check("t6_fast_byte", byte_at(0), 32'h96);
    check("t6_slow_byte", byte_at(1), 32'h96);
    check("t6_ferr", ferr_cnt, 0);
    check("t6_byte_hold", {24'h0, o_Rx_Byte}, 32'h96);

    check("strobe_overlap", both_cnt, 0);
    check("strobe_consecutive", consec_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
